// File: rtl/vram_blitter_if.sv
// vram_blitter_if: CPU-side VIDEO VRAM port as driven by the blitter (master) and served by VIDEO (slave).
interface vram_blitter_if #(parameter int AW = 13);
   logic          own;
   logic          sel;
   logic          we;
   logic [AW-1:0] addr;
   logic [7:0]    din;
   logic [7:0]    dout;
   logic          rdy;
   modport master(output own, sel, we, addr, din, input dout, rdy);
   modport slave(input own, sel, we, addr, din, output dout, rdy);
endinterface

// File: rtl/vram_blitter.sv
// vram_blitter: bus-master fill/copy engine for the VIDEO VRAM port, programmed through 8 byte registers.
module vram_blitter #(
   parameter int AW = 13,
   parameter int LW = 13
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       we,
   input  logic [2:0] ra,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   vram_blitter_if.master v
);
   typedef enum logic [2:0] {IDLE, RD_ISS, RD_WT, RD_STL, WR_ISS, WR_WT, WR_STL} state_t;
   state_t state, state_n, wr_next;
   logic [AW-1:0] dst, src;
   logic [LW-1:0] len;
   logic [7:0] fill, rbuf;
   logic op, dir, ien, done, abort;
   logic busy, wr_cs, go, stop, rd_done, wr_done, rd_ph, wr_ph;
   always_comb begin
      busy    = state != IDLE;
      wr_cs   = cs & we;
      go      = wr_cs && ra == 3'd7 && din[7];
      stop    = abort | (busy & go);
      rd_ph   = state == RD_ISS || state == RD_WT || state == RD_STL;
      wr_ph   = state == WR_ISS || state == WR_WT || state == WR_STL;
      rd_done = (state == RD_WT && v.rdy) || state == RD_STL;
      wr_done = (state == WR_WT && v.rdy) || state == WR_STL;
      wr_next = (len == LW'(1) || stop) ? IDLE : (op ? RD_ISS : WR_ISS);
      state_n = state;
      case (state)
         IDLE:    state_n = (go && len != '0) ? (din[0] ? RD_ISS : WR_ISS) : IDLE;
         RD_ISS:  state_n = RD_WT;
         RD_WT:   state_n = v.rdy ? (stop ? IDLE : WR_ISS) : RD_STL;
         RD_STL:  state_n = stop ? IDLE : WR_ISS;
         WR_ISS:  state_n = WR_WT;
         WR_WT:   state_n = v.rdy ? wr_next : WR_STL;
         WR_STL:  state_n = wr_next;
         default: state_n = IDLE;
      endcase
   end
   // Address/data are combinational from state and counters, so they stay stable through WT/STL.
   assign v.own  = busy;
   assign v.sel  = state == RD_ISS || state == WR_ISS;
   assign v.we   = wr_ph;
   assign v.addr = !busy ? '0 : (rd_ph ? src : dst);
   assign v.din  = !wr_ph ? '0 : (op ? rbuf : fill);
   assign irq    = done & ien;
   always_comb begin
      case (ra)
         3'd0:    dout = dst[7:0];
         3'd1:    dout = 8'(dst[AW-1:8]);
         3'd2:    dout = src[7:0];
         3'd3:    dout = 8'(src[AW-1:8]);
         3'd4:    dout = len[7:0];
         3'd5:    dout = 8'(len[LW-1:8]);
         3'd6:    dout = fill;
         default: dout = {busy, ien, 5'b0, done};
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         dst   <= '0;
         src   <= '0;
         len   <= '0;
         fill  <= '0;
         rbuf  <= '0;
         op    <= 1'b0;
         dir   <= 1'b0;
         ien   <= 1'b0;
         done  <= 1'b0;
         abort <= 1'b0;
      end else begin
         state <= state_n;
         if (wr_cs && !busy)
            case (ra)
               3'd0:    dst[7:0]    <= din;
               3'd1:    dst[AW-1:8] <= din[AW-9:0];
               3'd2:    src[7:0]    <= din;
               3'd3:    src[AW-1:8] <= din[AW-9:0];
               3'd4:    len[7:0]    <= din;
               3'd5:    len[LW-1:8] <= din[LW-9:0];
               3'd6:    fill        <= din;
               default: {ien, dir, op} <= {din[6], din[1], din[0]};
            endcase
         if (rd_done)
            rbuf <= v.dout;
         if (wr_done) begin
            dst <= dir ? dst - AW'(1) : dst + AW'(1);
            src <= dir ? src - AW'(1) : src + AW'(1);
            len <= len - LW'(1);
         end
         abort <= busy && stop && state_n != IDLE;
         // Order matters: a completion in the same cycle as a STATUS read must not be lost.
         if (cs && !we && ra == 3'd7)
            done <= 1'b0;
         if (go && !busy)
            done <= len == '0;
         if (busy && state_n == IDLE)
            done <= 1'b1;
      end
   end
endmodule

// File: tb/tb_vram_blitter.sv
// tb_vram_blitter: VRAM model plus write scoreboard exercising fill, copy, stalls, wrap, abort and reset.
module tb_vram_blitter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cs = 1'b0, we = 1'b0;
   logic [2:0] ra = '0;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic irq;
   vram_blitter_if #(.AW(13)) v();
   vram_blitter dut(.clk(clk), .reset(reset), .cs(cs), .we(we), .ra(ra), .din(din), .dout(dout), .irq(irq), .v(v));
   always #5 clk = ~clk;
   typedef struct {logic [12:0] a; logic [7:0] d;} wr_t;
   wr_t q[$];
   wr_t e;
   logic [7:0] mem [0:8191];
   logic [7:0] sh [0:8191];
   int checks = 0, errors = 0, wr_cnt = 0, sel_cnt = 0, own_cyc = 0;
   int stall_mode = 0;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // VIDEO model: acts on the strobe mid-cycle, answers with read data and rdy for the WT cycle.
   always @(negedge clk) begin
      if (reset) begin
         v.rdy  = 1'b1;
         v.dout = '0;
      end else begin
         if (v.own) own_cyc++;
         if (v.sel) begin
            sel_cnt++;
            v.dout = mem[v.addr];
            v.rdy  = !((stall_mode == 1 && !v.we) || (stall_mode == 2 && v.we));
            if (v.we) begin
               mem[v.addr] = v.din;
               wr_cnt++;
               if (q.size() == 0) chk("unexp_wr", 1, 0);
               else begin
                  e = q.pop_front();
                  chk("wr_addr", 32'(v.addr), 32'(e.a));
                  chk("wr_data", 32'(v.din), 32'(e.d));
               end
            end
         end
      end
   end
   task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      cs = 1; we = 1; ra = a; din = d;
      @(posedge clk); #1;
      cs = 0; we = 0;
   endtask
   task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
      @(posedge clk); #1;
      cs = 1; we = 0; ra = a;
      #2 d = dout;
      @(posedge clk); #1;
      cs = 0;
   endtask
   task automatic setup(input logic [12:0] dst, input logic [12:0] src, input logic [12:0] len, input logic [7:0] f);
      cpu_wr(0, dst[7:0]); cpu_wr(1, 8'(dst[12:8]));
      cpu_wr(2, src[7:0]); cpu_wr(3, 8'(src[12:8]));
      cpu_wr(4, len[7:0]); cpu_wr(5, 8'(len[12:8]));
      cpu_wr(6, f);
   endtask
   task automatic expect_op(input bit op, input bit dir, input logic [12:0] dst, input logic [12:0] src, input int len, input logic [7:0] f);
      wr_t w;
      sh = mem;
      for (int i = 0; i < len; i++) begin
         w.a = dst;
         w.d = op ? sh[src] : f;
         sh[dst] = w.d;
         q.push_back(w);
         dst = dir ? dst - 13'd1 : dst + 13'd1;
         src = dir ? src - 13'd1 : src + 13'd1;
      end
   endtask
   task automatic wait_idle(input int bound);
      int n = 0;
      while (v.own && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      if (v.own) chk("timeout", 1, 0);
   endtask
   initial begin
      logic [7:0] d;
      int c0, w0, n, mism;
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      repeat (3) @(posedge clk);
      #1 reset = 0;
      chk("rst_own", v.own, 0);
      chk("rst_sel", v.sel, 0);
      chk("rst_addr", 32'(v.addr), 0);
      chk("rst_irq", irq, 0);
      for (int i = 0; i < 8; i++) begin
         cpu_rd(3'(i), d);
         chk("rst_reg", d, 0);
      end
      cpu_wr(1, 8'hFF); cpu_rd(1, d); chk("dst_hi_mask", d, 8'h1F);
      cpu_wr(6, 8'hA5); cpu_rd(6, d); chk("fill_rb", d, 8'hA5);
      // Screen clear
      setup(13'h1000, 13'h0000, 13'h0400, 8'h20);
      expect_op(0, 0, 13'h1000, 13'h0000, 'h400, 8'h20);
      c0 = own_cyc;
      cpu_wr(7, 8'h80);
      chk("first_sel", v.sel, 1);
      cpu_wr(6, 8'h55);
      wait_idle(5000);
      chk("fill_cyc", own_cyc - c0, 2048);
      chk("fill_q", q.size(), 0);
      cpu_rd(6, d); chk("busy_wr_ign", d, 8'h20);
      cpu_rd(7, d); chk("fill_done", d, 8'h01);
      cpu_rd(7, d); chk("done_clr", d, 8'h00);
      cpu_rd(4, d); chk("fill_len", d, 0);
      cpu_rd(1, d); chk("fill_dst_hi", d, 8'h14);
      // Text scroll up one row
      for (int i = 'h1000; i < 'h1400; i++) mem[i] = 8'($urandom);
      setup(13'h1000, 13'h1020, 13'h03E0, 8'h00);
      expect_op(1, 0, 13'h1000, 13'h1020, 'h3E0, 8'h00);
      c0 = own_cyc;
      cpu_wr(7, 8'h81);
      wait_idle(10000);
      chk("copy_cyc", own_cyc - c0, 3968);
      chk("copy_q", q.size(), 0);
      mism = 0;
      for (int i = 'h1000; i < 'h1400; i++) if (mem[i] !== sh[i]) mism++;
      chk("scroll_mem", mism, 0);
      // Single stall on the read, then on the write
      for (int k = 1; k <= 2; k++) begin
         setup(13'(13'h0100 + k), 13'(13'h0200 + k), 13'd1, 8'h00);
         expect_op(1, 0, 13'(13'h0100 + k), 13'(13'h0200 + k), 1, 8'h00);
         stall_mode = k;
         c0 = own_cyc;
         cpu_wr(7, 8'h81);
         wait_idle(50);
         stall_mode = 0;
         chk(k == 1 ? "rd_stall_cyc" : "wr_stall_cyc", own_cyc - c0, 5);
         chk("stall_q", q.size(), 0);
      end
      // Address wrap at the top of the window
      setup(13'h1FFE, 13'h0000, 13'd4, 8'hA5);
      expect_op(0, 0, 13'h1FFE, 13'h0000, 4, 8'hA5);
      c0 = own_cyc;
      cpu_wr(7, 8'h80);
      wait_idle(50);
      chk("wrap_cyc", own_cyc - c0, 8);
      chk("wrap_q", q.size(), 0);
      cpu_rd(0, d); chk("wrap_dst_lo", d, 8'h02);
      cpu_rd(1, d); chk("wrap_dst_hi", d, 8'h00);
      cpu_rd(7, d);
      // Zero length: done without any access
      setup(13'h0050, 13'h0000, 13'd0, 8'h11);
      n = sel_cnt;
      cpu_wr(7, 8'h80);
      repeat (3) @(posedge clk);
      #1;
      chk("len0_sel", sel_cnt - n, 0);
      chk("len0_own", v.own, 0);
      cpu_rd(7, d); chk("len0_done", d, 8'h01);
      // Decrementing overlapped copy
      setup(13'h020F, 13'h020B, 13'd8, 8'h00);
      expect_op(1, 1, 13'h020F, 13'h020B, 8, 8'h00);
      c0 = own_cyc;
      cpu_wr(7, 8'h83);
      wait_idle(100);
      chk("dec_cyc", own_cyc - c0, 32);
      chk("dec_q", q.size(), 0);
      cpu_rd(7, d);
      // Abort mid-copy with irq enabled
      setup(13'h0300, 13'h0400, 13'd100, 8'h00);
      expect_op(1, 0, 13'h0300, 13'h0400, 100, 8'h00);
      w0 = wr_cnt;
      cpu_wr(7, 8'hC1);
      n = 0;
      while (wr_cnt - w0 < 10 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      cpu_wr(7, 8'h80);
      wait_idle(100);
      n = wr_cnt - w0;
      chk("abort_cnt", n >= 10 && n <= 11, 1);
      chk("abort_q", q.size(), 100 - n);
      q.delete();
      chk("abort_irq", irq, 1);
      cpu_rd(4, d); chk("abort_len", d, 8'(100 - n));
      cpu_rd(0, d); chk("abort_dst", d, 8'(n));
      cpu_rd(7, d); chk("abort_status", d, 8'h41);
      chk("irq_clr", irq, 0);
      // Reset during a write strobe
      setup(13'h0500, 13'h0000, 13'd16, 8'h77);
      expect_op(0, 0, 13'h0500, 13'h0000, 16, 8'h77);
      cpu_wr(7, 8'h80);
      n = 0;
      while (!(v.sel && v.we) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("wr_iss_seen", v.sel && v.we, 1);
      reset = 1;
      @(posedge clk); #1;
      chk("rst_mid_sel", v.sel, 0);
      chk("rst_mid_own", v.own, 0);
      for (int i = 0; i < 8; i++) begin
         cpu_rd(3'(i), d);
         chk("rst_mid_reg", d, 0);
      end
      chk("rst_mid_irq", irq, 0);
      reset = 0;
      q.delete();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
